// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared constants and state encodings for the reaction-time trial
// Purpose: state encodings, LFSR tap mask and default Counter width shared by
//          reaction_sequencer and lfsr16.
// Ports:   none (package).
package reaction_pkg;

  localparam int CNT_W_DEF = 16;

  // Right-shift Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARM     = 3'd1;
  localparam state_t ST_WAIT    = 3'd2;
  localparam state_t ST_MEASURE = 3'd3;
  localparam state_t ST_DONE    = 3'd4;
  localparam state_t ST_FAULT   = 3'd5;

endpackage

// File: rtl/reaction_sequencer_if.sv
// rtl/reaction_sequencer_if.sv - control/status link between the sequencer and the 16-bit Counter
// Purpose: bundles the Counter control and status signals.
// Ports (modport master = sequencer side):
//   cnt_enable (out) Counter enable, cnt_clear (out) Counter synchronous clear,
//   count (in) Counter value, carry_out (in) Counter wrap pulse.
// Modport slave is the Counter side with directions reversed.
interface reaction_sequencer_if #(
  parameter int CNT_W = 16
);

  logic             cnt_enable;
  logic             cnt_clear;
  logic [CNT_W-1:0] count;
  logic             carry_out;

  modport master (output cnt_enable, output cnt_clear, input count, input carry_out);
  modport slave  (input cnt_enable, input cnt_clear, output count, output carry_out);

endinterface

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Fibonacci LFSR
// Purpose: pseudo-random source that advances on every clock, including right
//          after reset; shared with the display blinker.
// Ports: clk (in) clock, rstn (in) async active-low reset, q[15:0] (out) state.
// SEED must be non-zero or the register locks up at zero.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= SEED;
    end else begin
      q <= {^(q & LFSR_TAPS), q[15:1]};
    end
  end

endmodule

// File: rtl/reaction_sequencer.sv
// rtl/reaction_sequencer.sv - control FSM for one reaction-time trial
// Purpose: waits for start, waits a pseudo-random delay, lights GO, lets the
//          Counter run on 1 ms ticks and captures the count on the response.
// Ports:
//   clk, rstn               clock, async active-low reset
//   tick                    1 ms strobe
//   start_btn, resp_btn     single-cycle button pulses
//   cnt_bus                 Counter link (enable/clear out, count/carry in)
//   led_go, busy            GO lamp, trial in progress
//   result, result_valid    captured reaction time and its valid flag
//   false_start, timeout    early press / Counter wrap flags
module reaction_sequencer
  import reaction_pkg::*;
#(
  parameter int          CNT_W     = CNT_W_DEF,
  parameter int          DLY_MIN   = 1000,
  parameter int          DLY_RND_W = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tick,
  input  logic                 start_btn,
  input  logic                 resp_btn,
  reaction_sequencer_if.master cnt_bus,
  output logic                 led_go,
  output logic                 busy,
  output logic [CNT_W-1:0]     result,
  output logic                 result_valid,
  output logic                 false_start,
  output logic                 timeout
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] dly_cnt;
  logic [15:0]      lfsr_q;
  logic             unused_lfsr_hi;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rstn (rstn),
    .q    (lfsr_q)
  );

  // Only the low DLY_RND_W bits feed the delay.
  assign unused_lfsr_hi = ^lfsr_q[15:DLY_RND_W];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_btn) state_nxt = ST_ARM;
      ST_ARM:     state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (resp_btn)                                 state_nxt = ST_FAULT;
        else if (tick && (dly_cnt == CNT_W'(1)))      state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (cnt_bus.carry_out)                        state_nxt = ST_FAULT;
        else if (resp_btn)                            state_nxt = ST_DONE;
      end
      ST_DONE, ST_FAULT: if (start_btn) state_nxt = ST_ARM;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Decoded straight from the inputs so the Counter freezes in the response
  // cycle itself and the captured count is the value shown at the press.
  always_comb begin
    cnt_bus.cnt_enable = (state == ST_MEASURE) && tick && !resp_btn;
    cnt_bus.cnt_clear  = (state == ST_IDLE) || (state == ST_ARM) || (state == ST_WAIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      dly_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      led_go       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Lamp and busy follow the next state so they are glitch-free flops.
      led_go <= (state_nxt == ST_MEASURE);
      busy   <= (state_nxt == ST_ARM) || (state_nxt == ST_WAIT) || (state_nxt == ST_MEASURE);
      case (state)
        ST_ARM: begin
          dly_cnt      <= CNT_W'(DLY_MIN) + CNT_W'(lfsr_q[DLY_RND_W-1:0]);
          result       <= '0;
          result_valid <= 1'b0;
          false_start  <= 1'b0;
          timeout      <= 1'b0;
        end
        ST_WAIT: begin
          if (tick)     dly_cnt     <= dly_cnt - CNT_W'(1);
          if (resp_btn) false_start <= 1'b1;
        end
        ST_MEASURE: begin
          // A wrap beats a simultaneous response.
          if (cnt_bus.carry_out) begin
            timeout <= 1'b1;
          end else if (resp_btn) begin
            result       <= cnt_bus.count;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_sequencer.sv
// tb/tb_reaction_sequencer.sv - self-checking bench for reaction_sequencer
module tb_reaction_sequencer;

  localparam int PI = 0, PA = 1, PW = 2, PM = 3, PD = 4, PF = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tick, start_btn, resp_btn, preload;
  logic        led_go, busy, result_valid, false_start, timeout;
  logic [15:0] result;
  int          tick_pct;
  int          checks = 0;
  int          failures = 0;

  reaction_sequencer_if #(.CNT_W(16)) cnt_bus ();

  reaction_sequencer dut (
    .clk          (clk),
    .rstn         (rstn),
    .tick         (tick),
    .start_btn    (start_btn),
    .resp_btn     (resp_btn),
    .cnt_bus      (cnt_bus),
    .led_go       (led_go),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Counter: clear wins, then a bench preload hook, then counting with a wrap pulse.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_bus.count     <= 16'h0;
      cnt_bus.carry_out <= 1'b0;
    end else begin
      cnt_bus.carry_out <= 1'b0;
      if (cnt_bus.cnt_clear)       cnt_bus.count <= 16'h0;
      else if (preload)            cnt_bus.count <= 16'hFFF0;
      else if (cnt_bus.cnt_enable) begin
        cnt_bus.count     <= cnt_bus.count + 16'h1;
        cnt_bus.carry_out <= (cnt_bus.count == 16'hFFFF);
      end
    end
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Behavioural model: trial phase, ticks left until GO, ticks measured since GO.
  int          m_ph, m_left, m_dly_load;
  logic [15:0] m_lfsr, m_meas, e_result;
  logic        e_rv, e_fs, e_to;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph <= PI; m_lfsr <= 16'hACE1; m_left <= 0; m_meas <= 16'h0;
      e_result <= 16'h0; e_rv <= 1'b0; e_fs <= 1'b0; e_to <= 1'b0;
    end else begin
      m_lfsr <= lfsr_next(m_lfsr);
      if (m_ph inside {PI, PA, PW})               m_meas <= 16'h0;
      else if (preload)                           m_meas <= 16'hFFF0;
      else if (m_ph == PM && tick && !resp_btn)   m_meas <= m_meas + 16'h1;
      case (m_ph)
        PI, PD, PF: if (start_btn) m_ph <= PA;
        PA: begin
          m_left     <= 1000 + int'(m_lfsr % 16'd2048);
          m_dly_load <= 1000 + int'(m_lfsr % 16'd2048);
          e_result <= 16'h0; e_rv <= 1'b0; e_fs <= 1'b0; e_to <= 1'b0;
          m_ph <= PW;
        end
        PW: begin
          if (resp_btn) begin
            e_fs <= 1'b1; m_ph <= PF;
          end else if (tick) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_ph <= PM;
          end
        end
        PM: begin
          if (cnt_bus.carry_out) begin
            e_to <= 1'b1; m_ph <= PF;
          end else if (resp_btn) begin
            e_result <= m_meas; e_rv <= 1'b1; m_ph <= PD;
          end
        end
        default: m_ph <= PI;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("led_go", led_go, m_ph == PM);
    chk("busy", busy, m_ph inside {PA, PW, PM});
    chk("result", result, e_result);
    chk("result_valid", result_valid, e_rv);
    chk("false_start", false_start, e_fs);
    chk("timeout", timeout, e_to);
    chk("cnt_enable", cnt_bus.cnt_enable, (m_ph == PM) && tick && !resp_btn);
    chk("cnt_clear", cnt_bus.cnt_clear, m_ph inside {PI, PA, PW});
    chk("count", cnt_bus.count, m_meas);
    chk("lfsr", dut.u_lfsr.q, m_lfsr);
    chk("flags_exclusive", ($countones({result_valid, false_start, timeout}) <= 1), 1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    tick      = ($urandom_range(0, 99) < tick_pct);
    start_btn = 1'b0;
    resp_btn  = 1'b0;
    preload   = 1'b0;
  endtask

  task automatic arm();
    cyc();
    chk("arm_busy", busy, 1);
    chk("arm_led_off", led_go, 0);
  endtask

  task automatic begin_trial();
    cyc();
    start_btn = 1'b1;
    arm();
  endtask

  // Counts ticks seen in WAIT until the lamp lights; stray start presses are sprinkled in.
  task automatic go_wait(output int n_ticks);
    bit seen = 0;
    n_ticks = 0;
    for (int i = 0; i < 8000; i++) begin
      cyc();
      if (i == 0) begin
        chk("wait_flags_clear", {result_valid, false_start, timeout}, 0);
        chk("wait_result_clear", result, 0);
      end
      if (led_go) begin
        seen = 1;
        break;
      end
      n_ticks += int'(tick);
      if ($urandom_range(0, 49) == 0) start_btn = 1'b1;
    end
    chk("go_seen", seen, 1);
    chk("go_delay_ticks", n_ticks, m_dly_load);
  endtask

  // Called in the first MEASURE cycle; presses resp once n ticks have been counted.
  task automatic respond_after(input int n);
    int m = 0;
    for (int i = 0; i < 4000 && m < n; i++) begin
      m += int'(tick);
      cyc();
    end
    resp_btn = 1'b1;
  endtask

  task automatic start_when_low(input logic [10:0] want);
    bit found = 0;
    logic [15:0] nx;
    for (int i = 0; i < 30000; i++) begin
      cyc();
      nx = lfsr_next(m_lfsr);
      if (nx[10:0] == want) begin
        start_btn = 1'b1;
        found = 1;
        break;
      end
    end
    chk("lfsr_pattern_found", found, 1);
  endtask

  task automatic early_press(input int k);
    int m = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      m += int'(tick);
      if (m >= k) break;
    end
    cyc();
    resp_btn = 1'b1;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    rstn = 1'b0; tick = 1'b0; start_btn = 1'b0; resp_btn = 1'b0; preload = 1'b0;
    tick_pct = 75;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led_go", led_go, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_cnt_clear", cnt_bus.cnt_clear, 1);
    chk("rst_cnt_enable", cnt_bus.cnt_enable, 0);
    rstn = 1'b1;
    cyc();
    chk("lfsr_step1", dut.u_lfsr.q, 16'h5670);
    cyc();
    chk("lfsr_step2", dut.u_lfsr.q, 16'hAB38);

    // Normal trial: response 250 ticks after GO.
    repeat ($urandom_range(1, 20)) cyc();
    begin_trial();
    go_wait(n);
    respond_after(250);
    cyc();
    chk("normal_result", result, 250);
    chk("normal_valid", result_valid, 1);
    chk("normal_led", led_go, 0);
    chk("normal_busy", busy, 0);
    chk("normal_flags", {false_start, timeout}, 0);

    // Restart from DONE, respond in the very first GO cycle.
    begin_trial();
    go_wait(n);
    respond_after(0);
    cyc();
    chk("zero_result", result, 0);
    chk("zero_valid", result_valid, 1);

    // Delay bounds via start timing against the LFSR sequence.
    start_when_low(11'h000);
    arm();
    go_wait(n);
    chk("dly_min", n, 1000);
    respond_after($urandom_range(0, 20));
    cyc();
    start_when_low(11'h7FF);
    arm();
    go_wait(n);
    chk("dly_max", n, 3047);
    respond_after($urandom_range(0, 20));
    cyc();

    // False start 10 ticks into the wait.
    begin_trial();
    early_press(10);
    chk("fs_flag", false_start, 1);
    chk("fs_valid", result_valid, 0);
    chk("fs_led", led_go, 0);
    chk("fs_count", cnt_bus.count, 0);

    // Timeout with no response (Counter preloaded near wrap).
    begin_trial();
    go_wait(n);
    tick_pct = 100;
    preload = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (timeout) begin seen = 1; break; end
    end
    chk("to_seen", seen, 1);
    chk("to_valid", result_valid, 0);

    // Response in the same cycle as the wrap still times out.
    begin_trial();
    go_wait(n);
    preload = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (cnt_bus.carry_out) begin resp_btn = 1'b1; seen = 1; break; end
    end
    chk("to_carry_seen", seen, 1);
    cyc();
    chk("to_resp_timeout", timeout, 1);
    chk("to_resp_valid", result_valid, 0);
    tick_pct = 75;

    // Random mix of good trials and early presses.
    for (int t = 0; t < 4; t++) begin
      begin_trial();
      if ($urandom_range(0, 2) == 0) begin
        early_press($urandom_range(0, 30));
      end else begin
        go_wait(n);
        respond_after($urandom_range(0, 300));
        cyc();
      end
      chk("rand_idle", busy, 0);
    end

    // Asynchronous reset in the middle of MEASURE.
    begin_trial();
    go_wait(n);
    repeat (5) cyc();
    #3 rstn = 1'b0;
    #1;
    chk("arst_led_go", led_go, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_cnt_clear", cnt_bus.cnt_clear, 1);
    chk("arst_cnt_enable", cnt_bus.cnt_enable, 0);
    cyc();
    cyc();
    rstn = 1'b1;
    repeat (5) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
